// File: rtl/anc_pkg.sv
// Shared types and defaults for the ANC frame sequencer.
package anc_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 1500;
    localparam int CNT_W_DEF          = 8;

    // Encoding is visible on state_out: IDLE=0, then stages in frame order.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LP   = 3'd1,
        ST_ERR  = 3'd2,
        ST_LMS  = 3'd3,
        ST_FIR  = 3'd4,
        ST_DLY  = 3'd5
    } state_e;

    // One-hot start vector {dly, fir, lms, err, lp} for the stage being entered.
    function automatic logic [4:0] start_mask(state_e s);
        case (s)
            ST_LP:   return 5'b00001;
            ST_ERR:  return 5'b00010;
            ST_LMS:  return 5'b00100;
            ST_FIR:  return 5'b01000;
            ST_DLY:  return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         inc_in,
    input  logic         clr_in,
    output logic [W-1:0] value_out
);

    logic [W-1:0] value_q, value_d;

    // Next value: clear, else increment unless already at all-ones.
    always_comb begin
        // NOTE: default assignment first, so every path drives value_d and no latch is inferred.
        value_d = value_q;
        if (clr_in) begin
            value_d = '0;
        end else if (inc_in && (value_q != '1)) begin
            value_d = value_q + W'(1);
        end
    end

    // Count register, async reset to zero.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (rst_in) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_out = value_q;

endmodule

// File: rtl/anc_sequencer.sv
// Per-sample ANC pipeline sequencer: LP -> ERR -> (LMS) -> FIR -> DLY with
// per-stage timeout, overrun/timeout statistics and a completed-frame count.
module anc_sequencer
    import anc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             sample_pulse_in,
    input  logic             adapt_en_in,
    input  logic             clear_in,
    input  logic             lp_done_in,
    input  logic             err_done_in,
    input  logic             lms_done_in,
    input  logic             fir_done_in,
    input  logic             dly_done_in,
    output logic             lp_start_out,
    output logic             err_start_out,
    output logic             lms_start_out,
    output logic             fir_start_out,
    output logic             dly_start_out,
    output logic             busy_out,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] overrun_cnt_out,
    output logic [CNT_W-1:0] timeout_cnt_out,
    output logic             timeout_flag_out,
    output logic [15:0]      frame_cnt_out
);

    localparam int CYC_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [4:0]       start_q, start_d;
    logic [15:0]      frame_q, frame_d;
    logic             flag_q, flag_d;

    logic done_cur;
    logic entering;
    logic overrun_inc;
    logic timeout_inc;
    logic frame_inc;

    // Next-state, stage-cycle counter, start pulses and event strobes.
    always_comb begin
        state_d     = state_q;
        done_cur    = 1'b0;
        timeout_inc = 1'b0;
        frame_inc   = 1'b0;

        case (state_q)
            ST_IDLE: if (sample_pulse_in) state_d = ST_LP;
            ST_LP: begin
                done_cur = lp_done_in;
                if (lp_done_in) state_d = ST_ERR;
            end
            ST_ERR: begin
                done_cur = err_done_in;
                if (err_done_in) state_d = adapt_en_in ? ST_LMS : ST_FIR;
            end
            ST_LMS: begin
                done_cur = lms_done_in;
                if (lms_done_in) state_d = ST_FIR;
            end
            ST_FIR: begin
                done_cur = fir_done_in;
                if (fir_done_in) state_d = ST_DLY;
            end
            ST_DLY: begin
                done_cur = dly_done_in;
                if (dly_done_in) begin
                    frame_inc = 1'b1;
                    // A sample arriving exactly at frame end starts the next frame.
                    state_d   = sample_pulse_in ? ST_LP : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A done on the last allowed cycle still wins over the abort.
        if ((state_q != ST_IDLE) && !done_cur &&
            (cyc_q == CYC_W'(TIMEOUT_CYCLES - 1))) begin
            state_d     = ST_IDLE;
            timeout_inc = 1'b1;
        end

        overrun_inc = sample_pulse_in && (state_q != ST_IDLE) &&
                      !((state_q == ST_DLY) && dly_done_in);

        entering = (state_d != state_q);
        cyc_d    = (entering || (state_q == ST_IDLE)) ? '0 : cyc_q + CYC_W'(1);
        start_d  = entering ? start_mask(state_d) : 5'b00000;
        frame_d  = clear_in ? 16'd0 : (frame_inc ? frame_q + 16'd1 : frame_q);
        flag_d   = clear_in ? 1'b0 : (flag_q | timeout_inc);
    end

    // State, stage timer, start pulses, frame count and sticky flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            start_q <= 5'b00000;
            frame_q <= 16'd0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            start_q <= start_d;
            frame_q <= frame_d;
            flag_q  <= flag_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_overrun_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (overrun_inc),
        .clr_in    (clear_in),
        .value_out (overrun_cnt_out)
    );

    sat_counter #(.W(CNT_W)) u_timeout_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (timeout_inc),
        .clr_in    (clear_in),
        .value_out (timeout_cnt_out)
    );

    assign {dly_start_out, fir_start_out, lms_start_out, err_start_out, lp_start_out} = start_q;
    assign busy_out         = (state_q != ST_IDLE);
    assign state_out        = state_q;
    assign frame_cnt_out    = frame_q;
    assign timeout_flag_out = flag_q;

endmodule

// File: tb/tb_anc_sequencer.sv
// Self-checking bench for anc_sequencer: directed scenarios plus randomized
// traffic compared cycle by cycle against a stage-index reference model.
module tb_anc_sequencer;

    localparam int T   = 1500;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          sample_pulse_in, adapt_en_in, clear_in;
    logic          lp_done_in, err_done_in, lms_done_in, fir_done_in, dly_done_in;
    logic          lp_start_out, err_start_out, lms_start_out, fir_start_out, dly_start_out;
    logic          busy_out;
    logic [2:0]    state_out;
    logic [CW-1:0] overrun_cnt_out, timeout_cnt_out;
    logic          timeout_flag_out;
    logic [15:0]   frame_cnt_out;

    anc_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .sample_pulse_in  (sample_pulse_in),
        .adapt_en_in      (adapt_en_in),
        .clear_in         (clear_in),
        .lp_done_in       (lp_done_in),
        .err_done_in      (err_done_in),
        .lms_done_in      (lms_done_in),
        .fir_done_in      (fir_done_in),
        .dly_done_in      (dly_done_in),
        .lp_start_out     (lp_start_out),
        .err_start_out    (err_start_out),
        .lms_start_out    (lms_start_out),
        .fir_start_out    (fir_start_out),
        .dly_start_out    (dly_start_out),
        .busy_out         (busy_out),
        .state_out        (state_out),
        .overrun_cnt_out  (overrun_cnt_out),
        .timeout_cnt_out  (timeout_cnt_out),
        .timeout_flag_out (timeout_flag_out),
        .frame_cnt_out    (frame_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stage index 0=idle, 1..5 = LP,ERR,LMS,FIR,DLY.
    int         m_stage, m_elapsed, m_over, m_tout, m_frame;
    bit         m_flag;
    logic [4:0] m_start;
    int         lms_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_stage = 0; m_elapsed = 0; m_over = 0; m_tout = 0; m_frame = 0;
        m_flag = 1'b0; m_start = 5'd0;
    endfunction

    function automatic void model_step(bit s, bit a, bit c, logic [4:0] d);
        int nxt  = m_stage;
        bit done = 1'b0;
        bit tinc = 1'b0, finc = 1'b0, oinc = 1'b0;
        if (m_stage == 0) begin
            if (s) nxt = 1;
        end else begin
            done = d[m_stage-1];
            if (done) begin
                case (m_stage)
                    1:       nxt = 2;
                    2:       nxt = a ? 3 : 4;
                    3:       nxt = 4;
                    4:       nxt = 5;
                    default: begin finc = 1'b1; nxt = s ? 1 : 0; end
                endcase
            end else if (m_elapsed == T - 1) begin
                nxt  = 0;
                tinc = 1'b1;
            end
            oinc = s && !(m_stage == 5 && done);
        end
        m_start   = (nxt != m_stage && nxt != 0) ? 5'(1 << (nxt - 1)) : 5'd0;
        m_elapsed = (nxt != m_stage || nxt == 0) ? 0 : m_elapsed + 1;
        m_stage   = nxt;
        if (c) begin
            m_over = 0; m_tout = 0; m_frame = 0; m_flag = 1'b0;
        end else begin
            if (oinc && m_over < SAT) m_over++;
            if (tinc && m_tout < SAT) m_tout++;
            if (tinc) m_flag = 1'b1;
            if (finc) m_frame = (m_frame + 1) % 65536;
        end
    endfunction

    task automatic compare_all();
        check("state", state_out, m_stage);
        check("start", {dly_start_out, fir_start_out, lms_start_out, err_start_out, lp_start_out}, m_start);
        check("busy", busy_out, (m_stage != 0));
        check("overrun", overrun_cnt_out, m_over);
        check("timeout_cnt", timeout_cnt_out, m_tout);
        check("timeout_flag", timeout_flag_out, m_flag);
        check("frame", frame_cnt_out, m_frame);
        if (lms_start_out) lms_seen++;
    endtask

    task automatic drive(input bit s, input bit a, input bit c, input logic [4:0] d);
        sample_pulse_in = s;
        adapt_en_in     = a;
        clear_in        = c;
        {dly_done_in, fir_done_in, lms_done_in, err_done_in, lp_done_in} = d;
    endtask

    // One clock: check current outputs, apply this cycle's inputs, advance model.
    task automatic tick(input bit s, input bit a, input bit c, input logic [4:0] d);
        @(negedge clk_in);
        compare_all();
        drive(s, a, c, d);
        model_step(s, a, c, d);
    endtask

    // Run one frame, answering each stage `delay` cycles after its start.
    task automatic run_frame(input bit kick, input bit adapt, input int delay,
                             input int withhold, input int stop_stage, input bit smp_end);
        bit finished = 1'b0;
        if (kick) tick(1'b1, adapt, 1'b0, 5'd0);
        for (int k = 0; k < 5000; k++) begin
            logic [4:0] d = 5'd0;
            bit         s = 1'b0;
            if (m_stage == 0 || m_stage == stop_stage) begin
                finished = 1'b1;
                break;
            end
            if (m_stage != withhold && m_elapsed == delay) begin
                d[m_stage-1] = 1'b1;
                if (m_stage == 5 && smp_end) s = 1'b1;
            end
            tick(s, adapt, 1'b0, d);
            if (d[4]) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check("frame_bound", 0, 1);
    endtask

    task automatic random_run(input int n, input int p_smp, input int p_done, input int p_clr);
        for (int i = 0; i < n; i++) begin
            logic [4:0] d;
            for (int b = 0; b < 5; b++) d[b] = (($urandom % 100) < p_done);
            tick((($urandom % 1000) < p_smp), 1'($urandom % 2), (($urandom % 1000) < p_clr), d);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0);
        model_reset();
        lms_seen = 0;
        #3;
        compare_all();
        @(negedge clk_in);
        #1 rst_in = 1'b0;

        // Full frame with adaptation, 10-cycle stage latency.
        tick(1'b0, 1'b1, 1'b0, 5'd0);
        lms_seen = 0;
        run_frame(1'b1, 1'b1, 10, 0, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 5'd0);
        check("adapt_frame_count", frame_cnt_out, 1);
        check("adapt_busy_low", busy_out, 0);
        check("adapt_lms_once", lms_seen, 1);

        // Adaptation disabled: LMS is skipped.
        lms_seen = 0;
        run_frame(1'b1, 1'b0, 3, 0, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 5'd0);
        check("noadapt_lms_none", lms_seen, 0);
        check("noadapt_frame_count", frame_cnt_out, 2);

        // Overruns: 3, then 300 total saturates.
        tick(1'b0, 1'b1, 1'b1, 5'd0);
        tick(1'b1, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 5'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd0);
        check("overrun_three", overrun_cnt_out, 3);
        for (int i = 0; i < 297; i++) tick(1'b1, 1'b1, 1'b0, 5'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd0);
        check("overrun_saturate", overrun_cnt_out, SAT);
        run_frame(1'b0, 1'b1, 0, 1, 0, 1'b0);   // let LP time out

        // LMS done withheld: abort at the timeout, then a clean frame.
        tick(1'b0, 1'b1, 1'b1, 5'd0);
        run_frame(1'b1, 1'b1, 3, 3, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 5'd0);
        check("lms_timeout_cnt", timeout_cnt_out, 1);
        check("lms_timeout_flag", timeout_flag_out, 1);
        check("lms_timeout_frame", frame_cnt_out, 0);
        run_frame(1'b1, 1'b1, 2, 0, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 5'd0);
        check("post_timeout_frame", frame_cnt_out, 1);

        // DLY done coincident with a sample: back-to-back frame, no overrun.
        tick(1'b0, 1'b1, 1'b1, 5'd0);
        run_frame(1'b1, 1'b1, 4, 0, 0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 5'd0);
        check("b2b_lp_state", state_out, 1);
        check("b2b_overrun", overrun_cnt_out, 0);
        check("b2b_frame", frame_cnt_out, 1);
        run_frame(1'b0, 1'b1, 1, 0, 0, 1'b0);

        // Asynchronous reset while in FIR, then a stray FIR done.
        run_frame(1'b1, 1'b1, 2, 0, 4, 1'b0);
        @(posedge clk_in);
        #1 check("pre_reset_fir", state_out, 4);
        drive(1'b0, 1'b1, 1'b0, 5'd0);
        #1 rst_in = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_reset_state", state_out, 0);
        @(negedge clk_in);
        compare_all();
        #1 rst_in = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 5'b01000);
        tick(1'b0, 1'b1, 1'b0, 5'd0);
        check("stray_done_idle", state_out, 0);

        // Randomized traffic: mixed, timeout-heavy, and sample-heavy.
        random_run(4000, 30, 20, 3);
        random_run(3500, 5, 0, 0);
        random_run(2000, 300, 40, 5);
        tick(1'b0, 1'b0, 1'b0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/anc_sequencer.md
ANC_SEQUENCER -- requirements
Module: anc_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1500, max cycles any stage may take before abort (one 64 kHz sample period ≈ 1562 cycles at 100 MHz).
REQ-002 Parameter: CNT_W, 8, width of saturating fault counters.
REQ-003 clk_in  input  1  100 MHz system clock; the block uses this single clock.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 sample_pulse_in  input  1  one-cycle pulse: new mic sample pair available.
REQ-006 adapt_en_in  input  1  high: run coefficient update stage; low: skip it.
REQ-007 clear_in  input  1  synchronous clear of counters and sticky flag.
REQ-008 lp_done_in, err_done_in, lms_done_in, fir_done_in, dly_done_in  input  1 each  stage completion pulses.
REQ-009 lp_start_out, err_start_out, lms_start_out, fir_start_out, dly_start_out  output  1 each  one-cycle stage start pulses.
REQ-010 busy_out  output  1  high whenever state is not IDLE.
REQ-011 state_out  output  3  current state encoding.
REQ-012 overrun_cnt_out  output  CNT_W  dropped-sample count, saturating.
REQ-013 timeout_cnt_out  output  CNT_W  aborted-frame count, saturating.
REQ-014 timeout_flag_out  output  1  sticky: at least one timeout since reset/clear.
REQ-015 frame_cnt_out  output  16  completed frames, wraps 0xFFFF->0.

Function
REQ-016 States: IDLE, LP, ERR, LMS, FIR, DLY; sequence IDLE->LP->ERR->LMS->FIR->DLY->IDLE.
REQ-017 sample_pulse_in high in IDLE at cycle N: state=LP and lp_start_out=1 at cycle N+1.
REQ-018 Every start pulse is registered, high exactly one cycle, coincident with the first cycle of its state.
REQ-019 In a wait state, its done input high (including the start cycle) advances state next cycle and fires the next stage's start pulse.
REQ-020 ERR done with adapt_en_in=0 goes to FIR (no lms_start_out); adapt_en_in is sampled only at that transition.
REQ-021 DLY done: frame_cnt_out increments, state returns to IDLE next cycle.
REQ-022 DLY done coincident with sample_pulse_in: go directly to LP with lp_start_out next cycle; frame counted, no overrun.
REQ-023 sample_pulse_in in any non-IDLE state (except REQ-022 case): sample dropped, overrun_cnt_out +1, saturating at 2^CNT_W-1.
REQ-024 Per-state cycle counter resets on every state entry; reaching TIMEOUT_CYCLES without done: state->IDLE, timeout_cnt_out +1 (saturating), timeout_flag_out=1, no frame count.
REQ-025 Done pulses for a stage other than the current one are ignored.
REQ-026 clear_in zeroes overrun, timeout and frame counters and timeout flag; does not change state; clear wins over a same-cycle increment.

Reset
REQ-027 rst_in asserted: state IDLE, all start pulses 0, busy_out 0, all counters 0, timeout_flag_out 0, immediately and regardless of clock.
REQ-028 Reset mid-frame aborts the frame without a frame count; no start pulse issues in the first cycle after deassertion.

Structure
REQ-029 Shared package anc_pkg holds the state enum typedef, the TIMEOUT_CYCLES default and the CNT_W default.
REQ-030 One sub-module sat_counter (width parameter, inc, clr, value) instantiated for overrun and timeout counts.

Verification
REQ-031 Sample pulse, each done 10 cycles after its start, adapt_en=1 -> five start pulses in order, frame_cnt=1, busy low after DLY done.
REQ-032 adapt_en=0 -> lms_start_out never pulses, fir_start_out the cycle after err_done_in, frame completes.
REQ-033 Three sample pulses during one frame -> overrun_cnt=3; 300 such -> saturates at 255.
REQ-034 lms_done withheld -> at cycle TIMEOUT_CYCLES in LMS return to IDLE, timeout_cnt=1, flag=1, frame_cnt unchanged; next sample starts a clean frame.
REQ-035 dly_done_in and sample_pulse_in same cycle -> lp_start_out next cycle, overrun_cnt unchanged, frame_cnt +1.
REQ-036 rst_in pulsed while in FIR -> state IDLE asynchronously, all outputs zero, stray fir_done_in afterwards ignored.
